// File: rtl/amiq_dvcon_tb_vip_red_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module   : amiq_dvcon_tb_vip_red_rec_fifo
// Brief    : Sequence-tagged FWFT record FIFO with drop accounting (red VIP)
// Revision : 1.0
// ============================================================================
module amiq_dvcon_tb_vip_red_rec_fifo #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 32,
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = 16,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_fields,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_fields,
  output logic [SEQ_W-1:0]              out_seq,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = NUM_FIELDS * FIELD_W;

  localparam logic [AW:0]       C_DEPTH    = (AW + 1)'(DEPTH);
  localparam logic [DROP_W-1:0] C_DROP_MAX = {DROP_W{1'b1}};

  logic [REC_W-1:0] r_mem_fields [DEPTH];
  logic [SEQ_W-1:0] r_mem_seq    [DEPTH];

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = w_valid & out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      // Tag advances on every strobe so that drops leave visible seq gaps.
      if (in_valid) r_seq <= r_seq + 1'b1;
      if (w_drop && (r_drop != C_DROP_MAX)) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem_fields[r_wr_ptr] <= in_fields;
      r_mem_seq[r_wr_ptr]    <= r_seq;
    end
  end

  // Head is gated so that unreset storage never leaks onto the outputs.
  assign out_valid  = w_valid;
  assign out_fields = w_valid ? r_mem_fields[r_rd_ptr] : '0;
  assign out_seq    = w_valid ? r_mem_seq[r_rd_ptr]    : '0;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = ~w_valid;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_amiq_dvcon_tb_vip_red_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_amiq_dvcon_tb_vip_red_rec_fifo
// Brief    : Scoreboard bench for the red-channel record FIFO
// Revision : 1.0
// ============================================================================
module tb_amiq_dvcon_tb_vip_red_rec_fifo;

  localparam int NF     = 3;
  localparam int FW     = 8;
  localparam int DEPTH  = 8;
  localparam int SEQ_W  = 4;
  localparam int DROP_W = 3;
  localparam int RW     = NF * FW;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic [RW-1:0]     in_fields;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_fields;
  logic [SEQ_W-1:0]  out_seq;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [DROP_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  amiq_dvcon_tb_vip_red_rec_fifo #(
    .NUM_FIELDS (NF),
    .FIELD_W    (FW),
    .DEPTH      (DEPTH),
    .SEQ_W      (SEQ_W),
    .DROP_W     (DROP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_fields  (in_fields),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fields (out_fields),
    .out_seq    (out_seq),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_cnt   (drop_cnt)
  );

  typedef struct packed {
    logic [RW-1:0]    f;
    logic [SEQ_W-1:0] s;
  } rec_t;

  rec_t             sbq[$];
  logic [SEQ_W-1:0] m_seq;
  int               m_drop;
  int               total = 0;
  int               bad   = 0;

  // Checks the head against the scoreboard, advances the model, then clocks.
  task automatic step();
    rec_t exp;
    logic pop;
    logic full_m;
    total++;
    if (out_valid !== (sbq.size() != 0)) begin
      bad++;
      $display("FAIL sb_valid: got %b want %b", out_valid, (sbq.size() != 0));
    end
    if (sbq.size() != 0) begin
      exp = sbq[0];
      total++;
      if (out_fields !== exp.f || out_seq !== exp.s) begin
        bad++;
        $display("FAIL sb_head: got f=%h s=%0d want f=%h s=%0d",
                 out_fields, out_seq, exp.f, exp.s);
      end
    end
    pop    = out_ready && (sbq.size() != 0);
    full_m = (sbq.size() == DEPTH);
    if (clear) begin
      sbq.delete();
      m_seq  = '0;
      m_drop = 0;
    end else begin
      if (pop) void'(sbq.pop_front());
      if (in_valid) begin
        if (!full_m || pop) sbq.push_back({in_fields, m_seq});
        else if (m_drop < (1 << DROP_W) - 1) m_drop++;
        m_seq = m_seq + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_fields = RW'($urandom);
      out_ready = rdy;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget    = 4 * DEPTH;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d left want 0", sbq.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_fields = '0;
    sbq.delete(); m_seq = '0; m_drop = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    total++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
        drop_cnt !== '0 || out_seq !== '0 || out_fields !== '0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b v=%b d=%0d s=%0d fl=%h want 0 1 0 0 0 0 0",
               count, empty, full, out_valid, drop_cnt, out_seq, out_fields);
    end
    in_valid  = 1'b1;
    in_fields = {8'h33, 8'h22, 8'h11};
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_fields !== 24'h332211 || out_seq !== '0) begin
      bad++;
      $display("FAIL first_push: got v=%b f=%h s=%0d want 1 332211 0",
               out_valid, out_fields, out_seq);
    end
    drain();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_fields = RW'($urandom);
      out_ready = 1'b0;
      step();
      if (i == 7) begin
        total++;
        if (full !== 1'b1 || count !== CW'(DEPTH)) begin
          bad++;
          $display("FAIL full_flag: got f=%b cnt=%0d want 1 %0d", full, count, DEPTH);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (drop_cnt !== DROP_W'(2) || count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL overflow_drop: got d=%0d cnt=%0d want 2 %0d", drop_cnt, count, DEPTH);
    end
    push_n(6, 1'b0);
    total++;
    if (drop_cnt !== DROP_W'(7)) begin
      bad++;
      $display("FAIL drop_saturate: got %0d want 7", drop_cnt);
    end
    drain();
  endtask

  task automatic test_full_pop();
    do_clear();
    push_n(DEPTH, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_seq !== SEQ_W'(i)) begin
        bad++;
        $display("FAIL full_pop_seq: got %0d want %0d", out_seq, i);
      end
      in_valid  = 1'b1;
      in_fields = RW'($urandom);
      out_ready = 1'b1;
      step();
      total++;
      if (count !== CW'(DEPTH) || drop_cnt !== '0) begin
        bad++;
        $display("FAIL full_pop_cnt: got cnt=%0d d=%0d want %0d 0", count, drop_cnt, DEPTH);
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'b1;
      in_fields = RW'($urandom);
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b1 || count !== CW'(1) || out_seq !== SEQ_W'(i) || drop_cnt !== '0) begin
        bad++;
        $display("FAIL stream: got v=%b cnt=%0d s=%0d d=%0d want 1 1 %0d 0",
                 out_valid, count, out_seq, drop_cnt, i % 16);
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_clear();
    do_clear();
    push_n(DEPTH + 2, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    total++;
    if (count !== CW'(5) || drop_cnt !== DROP_W'(2)) begin
      bad++;
      $display("FAIL clear_setup: got cnt=%0d d=%0d want 5 2", count, drop_cnt);
    end
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_fields = RW'($urandom);
    out_ready = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (count !== '0 || empty !== 1'b1 || drop_cnt !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_prio: got cnt=%0d e=%b d=%0d v=%b want 0 1 0 0",
               count, empty, drop_cnt, out_valid);
    end
    push_n(1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_seq !== '0) begin
      bad++;
      $display("FAIL clear_seq: got v=%b s=%0d want 1 0", out_valid, out_seq);
    end
    drain();
  endtask

  task automatic test_async_reset();
    do_clear();
    push_n(6, 1'b0);
    total++;
    if (count !== CW'(6)) begin
      bad++;
      $display("FAIL areset_setup: got %0d want 6", count);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL areset_now: got e=%b v=%b cnt=%0d want 1 0 0", empty, out_valid, count);
    end
    sbq.delete(); m_seq = '0; m_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_n(1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_seq !== '0 || count !== CW'(1)) begin
      bad++;
      $display("FAIL areset_after: got v=%b s=%0d cnt=%0d want 1 0 1", out_valid, out_seq, count);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
